// File: rtl/caliptra_apb_req_driver_pkg.sv
`default_nettype none
// =============================================================================
// Package     : caliptra_apb_drv_pkg
// Description : Shared types and constants for the Caliptra APB request driver:
//               FSM state encoding, buffered request record, fixed pprot value.
// Revision    : 1.0 - initial release
// =============================================================================
package caliptra_apb_drv_pkg;

  // Field widths of the buffered request record; the driver's ADDR_W/DATA_W/
  // USER_W parameters default to these and must stay equal to them.
  localparam int APB_DRV_ADDR_W = 32;
  localparam int APB_DRV_DATA_W = 32;
  localparam int APB_DRV_USER_W = 32;

  // Requests are always issued as normal, secure, data accesses.
  localparam logic [2:0] APB_DRV_PPROT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_drv_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_DRV_ADDR_W-1:0] addr;
    logic [APB_DRV_DATA_W-1:0] wdata;
    logic [APB_DRV_USER_W-1:0] user;
  } apb_drv_req_t;

endpackage
`default_nettype wire

// File: rtl/caliptra_apb_req_driver_if.sv
`default_nettype none
// =============================================================================
// Interface   : caliptra_apb_req_driver_if
// Description : APB bus between the request driver (master) and the Caliptra
//               SoC-side APB completer (slave).
// Revision    : 1.0 - initial release
// =============================================================================
interface caliptra_apb_req_driver_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [USER_W-1:0] pauser;
  logic [2:0]        pprot;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pauser, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pauser, pprot,
    output pready, pslverr, prdata
  );
endinterface
`default_nettype wire

// File: rtl/caliptra_apb_req_driver_fifo.sv
`default_nettype none
// =============================================================================
// Module      : caliptra_apb_req_fifo
// Description : Synchronous request FIFO. Pointers carry one extra MSB so that
//               equal indices distinguish full (MSBs differ) from empty.
// Revision    : 1.0 - initial release
// =============================================================================
module caliptra_apb_req_fifo
  import caliptra_apb_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic         core_clk,
  input  wire logic         rst,
  input  wire logic         push,
  input  wire apb_drv_req_t push_data,
  input  wire logic         pop,
  output apb_drv_req_t      pop_data,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  apb_drv_req_t   r_mem [DEPTH];
  logic           w_push;
  logic           w_pop;

  // A push while full and a pop while empty are both ignored.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign pop_data = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Pointer advance; reset flushes all entries.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge core_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/caliptra_apb_req_driver.sv
`default_nettype none
// =============================================================================
// Module      : caliptra_apb_req_driver
// Description : Buffers valid/ready requests, runs each one through APB
//               SETUP/ACCESS with a pready timeout, and returns read data and
//               error status on a valid/ready response channel.
// Revision    : 1.0 - initial release
// =============================================================================
module caliptra_apb_req_driver
  import caliptra_apb_drv_pkg::*;
#(
  parameter int ADDR_W     = APB_DRV_ADDR_W,
  parameter int DATA_W     = APB_DRV_DATA_W,
  parameter int USER_W     = APB_DRV_USER_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256
) (
  input  wire logic              core_clk,
  input  wire logic              rst,
  input  wire logic              req_valid,
  output logic                   req_ready,
  input  wire logic              req_write,
  input  wire logic [ADDR_W-1:0] req_addr,
  input  wire logic [DATA_W-1:0] req_wdata,
  input  wire logic [USER_W-1:0] req_user,
  output logic                   rsp_valid,
  input  wire logic              rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  caliptra_apb_req_driver_if.master apb,
  output logic                   busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  apb_drv_state_e     r_state;
  apb_drv_state_e     w_state_nxt;
  apb_drv_req_t       w_fifo_in;
  apb_drv_req_t       w_fifo_out;
  apb_drv_req_t       r_xfer;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_done;
  logic               w_expire;
  logic               w_in_xfer;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_rsp_timeout;

  assign w_fifo_in.write = req_write;
  assign w_fifo_in.addr  = req_addr;
  assign w_fifo_in.wdata = req_wdata;
  assign w_fifo_in.user  = req_user;

  caliptra_apb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk  (core_clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (w_fifo_in),
    .pop       (w_pop),
    .pop_data  (w_fifo_out),
    .full      (w_full),
    .empty     (w_empty)
  );

  // State register.
  always_ff @(posedge core_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and ACCESS completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // pready wins over an expiring counter on the last allowed cycle.
        if (apb.pready) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_wait_cnt == C_CNT_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transfer register, wait counter and response register.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_xfer        <= '0;
      r_wait_cnt    <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_pop) r_xfer <= w_fifo_out;

      if (r_state == SETUP) begin
        r_wait_cnt <= '0;
      end else if (r_state == ACCESS && !apb.pready && r_wait_cnt != C_CNT_SAT) begin
        r_wait_cnt <= r_wait_cnt + C_CNT_ONE;
      end

      if (w_done) begin
        r_rsp_rdata   <= (!r_xfer.write && !apb.pslverr) ? apb.prdata : '0;
        r_rsp_err     <= apb.pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_expire) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else if (r_state == RESP && rsp_ready) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b0;
        r_rsp_timeout <= 1'b0;
      end
    end
  end

  // Request fields are only visible on the bus while a transfer is active.
  assign w_in_xfer   = (r_state == SETUP) || (r_state == ACCESS);
  assign apb.psel    = w_in_xfer;
  assign apb.penable = (r_state == ACCESS);
  assign apb.paddr   = w_in_xfer ? r_xfer.addr  : '0;
  assign apb.pwrite  = w_in_xfer ? r_xfer.write : 1'b0;
  assign apb.pwdata  = w_in_xfer ? r_xfer.wdata : '0;
  assign apb.pauser  = w_in_xfer ? r_xfer.user  : '0;
  assign apb.pprot   = APB_DRV_PPROT;

  assign req_ready   = !w_full;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = !w_empty || (r_state != IDLE);
endmodule
`default_nettype wire
